// File: rtl/spm_cfg_sequencer.sv
// spm_cfg_sequencer: captures an SPM program from the host into a shadow store,
// then on start clears the scratchpad, streams the program into it and steps
// through the contexts with run pulses, for a programmable number of passes.
// Optional build macro SPM_SEQ_PERF_CNT_EN adds the run_cycles busy-cycle counter.
module spm_cfg_sequencer #(
  parameter int unsigned INST_W = 24,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [INST_W-1:0] cfg_inst,
  input  logic              cfg_last,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        ctx_hold,
  input  logic [CNT_W-1:0]  iter_num,
  output logic              spm_clr,
  output logic              spm_init,
  output logic              spm_run,
  output logic [INST_W-1:0] spm_inst,
  output logic              busy,
  output logic              done,
`ifdef SPM_SEQ_PERF_CNT_EN
  output logic [31:0]       run_cycles,
`endif
  output logic [1:0]        err_code
);

  localparam int unsigned NW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_DONE, S_ABRT
  } state_t;

  state_t            state, state_nxt;
  logic [INST_W-1:0] shadow [DEPTH];
  logic [NW-1:0]     n_words;
  logic [NW-1:0]     k_idx;
  logic              prog_valid;
  logic [7:0]        hold_r;
  logic [7:0]        hcnt;
  logic [CNT_W-1:0]  iter_r;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  pass_inc;
  logic              start_ok;
  logic              cfg_acc;
  logic              last_word;
  logic              ctx_end;
  logic              pass_end;

  assign start_ok  = (state == S_IDLE) && start && prog_valid;
  assign cfg_acc   = (state == S_IDLE) && !start && cfg_valid;
  assign last_word = (k_idx == n_words - NW'(1));
  assign ctx_end   = (hcnt == hold_r - 8'd1);
  assign pass_end  = (state == S_RUN) && ctx_end && last_word;
  assign pass_inc  = pass_cnt + CNT_W'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort wins over every normal transition while sequencing
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = (iter_num == '0) ? S_DONE : S_CLEAR;
      S_CLEAR: state_nxt = abort ? S_ABRT : S_LOAD;
      S_LOAD: begin
        if (abort)          state_nxt = S_ABRT;
        else if (last_word) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (abort)         state_nxt = S_ABRT;
        else if (pass_end) state_nxt = (pass_inc < iter_r) ? S_CLEAR : S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ABRT:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from registered state and counters
  always_comb begin
    cfg_ready = 1'b0;
    spm_clr   = 1'b0;
    spm_init  = 1'b0;
    spm_run   = 1'b0;
    spm_inst  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  cfg_ready = !start && !rst;
      S_CLEAR: begin spm_clr = 1'b1; busy = 1'b1; end
      S_LOAD: begin
        spm_init = 1'b1;
        spm_inst = shadow[IW'(k_idx)];
        busy     = 1'b1;
      end
      S_RUN: begin
        spm_run = (hcnt == 8'd0);
        busy    = 1'b1;
      end
      S_DONE:  done = 1'b1;
      S_ABRT:  begin spm_clr = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  // Shadow store write; the first word after a complete program restarts at 0
  always_ff @(posedge clk) begin
    if (cfg_acc && (prog_valid || (n_words != NW'(DEPTH))))
      shadow[prog_valid ? IW'(0) : IW'(n_words)] <= cfg_inst;
  end

  // Program capture, start latching, error flags and sequencing counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_words    <= '0;
      prog_valid <= 1'b0;
      err_code   <= 2'b00;
      hold_r     <= 8'd1;
      iter_r     <= '0;
      pass_cnt   <= '0;
      k_idx      <= '0;
      hcnt       <= '0;
    end else begin
      if (cfg_acc) begin
        prog_valid <= cfg_last;
        if (prog_valid)                   n_words  <= NW'(1);
        else if (n_words == NW'(DEPTH))   err_code <= 2'b01;
        else                              n_words  <= n_words + NW'(1);
      end
      if ((state == S_IDLE) && start) begin
        if (prog_valid) begin
          err_code <= 2'b00;
          hold_r   <= (ctx_hold == 8'd0) ? 8'd1 : ctx_hold;
          iter_r   <= iter_num;
          pass_cnt <= '0;
        end else begin
          err_code <= 2'b10;
        end
      end
      if (pass_end) pass_cnt <= pass_inc;
      case (state)
        S_LOAD: k_idx <= last_word ? '0 : k_idx + NW'(1);
        S_RUN: begin
          hcnt <= ctx_end ? 8'd0 : hcnt + 8'd1;
          if (ctx_end) k_idx <= last_word ? '0 : k_idx + NW'(1);
        end
        default: begin
          k_idx <= '0;
          hcnt  <= 8'd0;
        end
      endcase
    end
  end

`ifdef SPM_SEQ_PERF_CNT_EN
  // Saturating count of busy cycles since the last accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               run_cycles <= '0;
    else if (start_ok)                     run_cycles <= '0;
    else if (busy && (run_cycles != '1))   run_cycles <= run_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_spm_cfg_sequencer.sv
// Bench for spm_cfg_sequencer: schedule-based reference model plus literal timelines.
module tb_spm_cfg_sequencer;

  localparam int unsigned INST_W = 24;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [INST_W-1:0] cfg_inst = '0;
  logic              cfg_last = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [7:0]        ctx_hold = 8'd0;
  logic [CNT_W-1:0]  iter_num = '0;
  logic              spm_clr, spm_init, spm_run, busy, done;
  logic [INST_W-1:0] spm_inst;
  logic [1:0]        err_code;
`ifdef SPM_SEQ_PERF_CNT_EN
  logic [31:0]       run_cycles;
`endif

  spm_cfg_sequencer #(.INST_W(INST_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_inst(cfg_inst), .cfg_last(cfg_last),
    .start(start), .abort(abort), .ctx_hold(ctx_hold), .iter_num(iter_num),
    .spm_clr(spm_clr), .spm_init(spm_init), .spm_run(spm_run), .spm_inst(spm_inst),
    .busy(busy), .done(done),
`ifdef SPM_SEQ_PERF_CNT_EN
    .run_cycles(run_cycles),
`endif
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one queue entry per expected cycle ----------------
  typedef struct packed {
    logic              clr;
    logic              init;
    logic              run;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;
    logic              abortable;
  } ent_t;

  ent_t              sched[$];
  logic [INST_W-1:0] prog[$];
  logic              m_pv  = 1'b0;
  logic [1:0]        m_err = 2'b00;
  logic [31:0]       m_rc  = '0;

  function automatic ent_t mk(input logic clr, input logic init, input logic run,
                              input logic [INST_W-1:0] inst, input logic bsy,
                              input logic dn, input logic ab);
    ent_t e;
    e.clr = clr; e.init = init; e.run = run; e.inst = inst;
    e.busy = bsy; e.done = dn; e.abortable = ab;
    return e;
  endfunction

  task automatic build_sched(input int unsigned hold, input int unsigned iters);
    int unsigned h;
    h = (hold == 0) ? 1 : hold;
    for (int unsigned p = 0; p < iters; p++) begin
      sched.push_back(mk(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1));
      foreach (prog[w]) sched.push_back(mk(1'b0, 1'b1, 1'b0, prog[w], 1'b1, 1'b0, 1'b1));
      foreach (prog[w])
        for (int unsigned c = 0; c < h; c++)
          sched.push_back(mk(1'b0, 1'b0, (c == 0), '0, 1'b1, 1'b0, 1'b1));
    end
    sched.push_back(mk(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0));
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sched.delete();
      prog.delete();
      m_pv  = 1'b0;
      m_err = 2'b00;
      m_rc  = '0;
    end else if (sched.size() != 0) begin
      if (sched[0].busy && (m_rc != 32'hFFFF_FFFF)) m_rc = m_rc + 32'd1;
      if (abort && sched[0].abortable) begin
        sched.delete();
        sched.push_back(mk(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0));
      end else begin
        void'(sched.pop_front());
      end
    end else if (start) begin
      if (!m_pv) m_err = 2'b10;
      else begin
        m_err = 2'b00;
        m_rc  = '0;
        build_sched(32'(ctx_hold), 32'(iter_num));
      end
    end else if (cfg_valid) begin
      if (m_pv) prog.delete();
      if (prog.size() == DEPTH) m_err = 2'b01;
      else prog.push_back(cfg_inst);
      m_pv = cfg_last;
    end
  end

  // Per-cycle comparison against the model
  ent_t cur;
  logic cur_ready;
  always @(negedge clk) begin
    if (sched.size() != 0) begin
      cur = sched[0];
      cur_ready = 1'b0;
    end else begin
      cur = '0;
      cur_ready = !start && !rst;
    end
    check("cfg_ready", 32'(cfg_ready), 32'(cur_ready));
    check("spm_clr",   32'(spm_clr),   32'(cur.clr));
    check("spm_init",  32'(spm_init),  32'(cur.init));
    check("spm_run",   32'(spm_run),   32'(cur.run));
    check("spm_inst",  32'(spm_inst),  32'(cur.inst));
    check("busy",      32'(busy),      32'(cur.busy));
    check("done",      32'(done),      32'(cur.done));
    check("err_code",  32'(err_code),  32'(m_err));
`ifdef SPM_SEQ_PERF_CNT_EN
    check("run_cycles", run_cycles, m_rc);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [INST_W-1:0] w, input logic last);
    cfg_valid = 1'b1;
    cfg_inst  = w;
    cfg_last  = last;
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  localparam logic [INST_W-1:0] WA = 24'h111111;
  localparam logic [INST_W-1:0] WB = 24'h222222;
  localparam logic [INST_W-1:0] WC = 24'h333333;
  localparam logic [INST_W-1:0] W0 = 24'hA5A5A5;
  localparam logic [INST_W-1:0] W1 = 24'h5A5A5A;

  initial begin
    // Reset state
    #1 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_err",   32'(err_code),  32'd0);
      check("rst_ready", 32'(cfg_ready), 32'd0);
      check("rst_inst",  32'(spm_inst),  32'd0);
    end
    tick();
    rst = 1'b0;
    tick();

    // Start without a program
    pulse_start();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("noprog_err",  32'(err_code), 32'd2);
      check("noprog_busy", 32'(busy),     32'd0);
      check("noprog_act",  32'({spm_clr, spm_init, spm_run}), 32'd0);
    end
    tick();

    // Three words, hold 2, one pass
    send_word(WA, 1'b0);
    send_word(WB, 1'b0);
    send_word(WC, 1'b1);
    ctx_hold = 8'd2;
    iter_num = CNT_W'(1);
    pulse_start();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check("t1_clr",  32'(spm_clr),  32'(c == 1));
      check("t1_init", 32'(spm_init), 32'(c >= 2 && c <= 4));
      check("t1_run",  32'(spm_run),  32'(c == 5 || c == 7 || c == 9));
      check("t1_done", 32'(done),     32'(c == 11));
      check("t1_busy", 32'(busy),     32'(c >= 1 && c <= 10));
      check("t1_inst", 32'(spm_inst), 32'((c == 2) ? WA : (c == 3) ? WB : (c == 4) ? WC : '0));
    end
    tick();

    // Two words, hold 0 (treated as 1), two passes
    send_word(W0, 1'b0);
    send_word(W1, 1'b1);
    ctx_hold = 8'd0;
    iter_num = CNT_W'(2);
    pulse_start();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check("t2_clr",  32'(spm_clr),  32'(c == 1 || c == 6));
      check("t2_init", 32'(spm_init), 32'(c == 2 || c == 3 || c == 7 || c == 8));
      check("t2_run",  32'(spm_run),  32'(c == 4 || c == 5 || c == 9 || c == 10));
      check("t2_done", 32'(done),     32'(c == 11));
      check("t2_inst", 32'(spm_inst), 32'((c == 2 || c == 7) ? W0 : (c == 3 || c == 8) ? W1 : '0));
`ifdef SPM_SEQ_PERF_CNT_EN
      if (c == 11) check("t2_run_cycles", run_cycles, 32'd10);
`endif
    end
    tick();

    // Abort during the second context, then replay
    ctx_hold = 8'd2;
    iter_num = CNT_W'(1);
    pulse_start();
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abrt_clr",  32'(spm_clr), 32'd1);
    check("abrt_busy", 32'(busy),    32'd1);
    check("abrt_run",  32'(spm_run), 32'd0);
    @(negedge clk);
    check("abrt_idle", 32'({spm_clr, busy, done}), 32'd0);
    tick();
    pulse_start();
    @(negedge clk);
    check("replay_clr", 32'(spm_clr), 32'd1);
    @(negedge clk);
    check("replay_inst", 32'(spm_inst), 32'(W0));
    repeat (12) tick();

    // Overflow: 17 words, no last
    for (int i = 0; i < 17; i++) send_word(INST_W'(i + 1), 1'b0);
    @(negedge clk);
    check("ovf_err",   32'(err_code),  32'd1);
    check("ovf_ready", 32'(cfg_ready), 32'd1);
    tick();
    pulse_start();
    @(negedge clk);
    check("ovf_start_err",  32'(err_code), 32'd2);
    check("ovf_start_busy", 32'(busy),     32'd0);
    tick();

    // Async reset in the middle of LOAD
    send_word(WA, 1'b0);
    send_word(WB, 1'b0);
    send_word(WC, 1'b1);
    ctx_hold = 8'd1;
    iter_num = CNT_W'(1);
    pulse_start();
    tick();
    check("pre_rst_init", 32'(spm_init), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_init", 32'(spm_init), 32'd0);
    check("arst_busy", 32'(busy),     32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    @(negedge clk);
    check("arst_start_err",  32'(err_code), 32'd2);
    check("arst_start_busy", 32'(busy),     32'd0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 5000; i++) begin
      cfg_valid = (($urandom % 3) == 0);
      cfg_inst  = INST_W'($urandom);
      cfg_last  = (($urandom % 5) == 0);
      start     = (($urandom % 25) == 0);
      abort     = (($urandom % 60) == 0);
      ctx_hold  = 8'($urandom_range(0, 3));
      iter_num  = CNT_W'($urandom_range(0, 2));
      tick();
    end
    cfg_valid = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
